data_ram_master: RTL and testbench
==================================

Name: data_ram_master

Overview:
- Initiator-side controller that drives the write and read ports of the 256x16 data RAM on behalf of the CPU datapath.
- Accepts single-word or burst load/store requests over a valid/ready handshake.
- Issues RAM write/read strobes and returns read data through a registered memory buffer (MBR) with response backpressure.
- Sits between the CPU control unit and the data RAM.

Parameters:
- ADDR_W, 8, RAM address width; also the burst length field width.
- DATA_W, 16, RAM data width.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_req_valid  in  1  request valid.
- o_req_ready  out  1  controller idle and able to accept a request.
- i_req_write  in  1  1 = fill (write), 0 = read.
- i_req_addr  in  ADDR_W  start address.
- i_req_len  in  ADDR_W  words minus one (0 means 1 word, 255 means 256 words).
- i_req_wdata  in  DATA_W  fill value, written to every word of the burst.
- o_rsp_valid  out  1  read word available on o_rsp_data.
- i_rsp_ready  in  1  consumer accepts the read word.
- o_rsp_data  out  DATA_W  MBR contents.
- o_rsp_last  out  1  marks the final word of a read burst, valid with o_rsp_valid.
- o_err  out  1  one-cycle request-rejected pulse (see Optional Feature).
- ctrl_write  out  1  RAM write strobe.
- o_addr_write  out  ADDR_W  RAM write address.
- o_data_write  out  DATA_W  RAM write data.
- ctrl_read  out  1  RAM read enable.
- o_addr_read  out  ADDR_W  RAM read address.
- i_data_read  in  DATA_W  RAM combinational read data.

Behaviour:
- Clock and reset: one clock, i_clk. Reset is asynchronous, active-low on i_rst_n.
- Reset values: state IDLE; o_req_ready=1; o_rsp_valid, o_rsp_last, o_err, ctrl_write, ctrl_read = 0; all address, data and MBR registers = 0.
- All RAM-side outputs are registered or decoded from the state register only; no combinational path from i_req_* to the RAM.
- State IDLE:
  - o_req_ready=1.
  - On i_req_valid & o_req_ready, latch addr_q, len_q (remaining count), wdata_q and write_q.
  - Go to WRITE if i_req_write=1, else READ.
- State WRITE:
  - ctrl_write=1, o_addr_write=addr_q, o_data_write=wdata_q.
  - Each cycle: addr_q+1 (mod 2^ADDR_W), len_q-1.
  - When len_q==0 at the strobe cycle, return to IDLE.
  - A burst of N words therefore takes N consecutive strobe cycles; o_req_ready returns 1 the cycle after the last strobe.
- State READ (one cycle):
  - ctrl_read=1, o_addr_read=addr_q.
  - MBR <= i_data_read at the clock edge; go to RSP.
- State RSP:
  - o_rsp_valid=1, o_rsp_data=MBR, o_rsp_last=(len_q==0). ctrl_read=0.
  - MBR and o_rsp_data hold stable while i_rsp_ready=0.
  - On i_rsp_ready: if len_q==0, go to IDLE; else addr_q+1 (mod 2^ADDR_W), len_q-1, go to READ.
- Read latency: handshake accepted at edge 0 -> READ in cycle 1 -> o_rsp_valid in cycle 2. Sustained throughput is 1 word per 2 cycles with i_rsp_ready held high.
- Boundary conditions:
  - i_req_valid while busy is ignored (o_req_ready=0); the requester must hold the request.
  - Address wrap: 255 -> 0 without error unless the optional feature is enabled.
  - len=255 with addr=0 covers the full RAM.
  - ctrl_write and ctrl_read are never asserted in the same cycle.
  - Reset asserted mid-burst: ctrl_write/ctrl_read drop immediately (asynchronous), no further RAM access, and the burst is not resumed after reset.

Optional Feature:
- Macro DATA_RAM_MASTER_BOUND_CHK_EN.
- Defined: a request with i_req_addr + i_req_len > 2^ADDR_W - 1 is still handshaken, but causes no RAM access and no response. o_err pulses high for exactly 1 cycle (the cycle after acceptance), then the controller returns to IDLE.
- Not defined: o_err is tied to 0 and addresses wrap modulo 2^ADDR_W.

Test Plan:
- Single fill, addr=0x10, len=0, wdata=0xBEEF -> exactly one ctrl_write cycle at o_addr_write=0x10, data 0xBEEF; o_req_ready=1 the next cycle.
- Read-back addr=0x10, len=0, i_rsp_ready=1 -> ctrl_read at 0x10 in cycle 1; o_rsp_valid with data 0xBEEF and o_rsp_last=1 in cycle 2; single response.
- Fill addr=0x20, len=3, wdata=0x1234, then read the same range with i_rsp_ready toggling 1,0,0,1... -> 4 responses of 0x1234, o_rsp_last only on the 4th, data stable while stalled, addresses 0x20..0x23 in order.
- Wrap: read addr=0xFE, len=2 -> addresses 0xFE, 0xFF, 0x00. With the macro enabled: o_err pulse, no ctrl_read, no o_rsp_valid.
- Reset: assert i_rst_n=0 during the 3rd strobe of a fill with len=7 -> ctrl_write low immediately; after release, state IDLE, o_req_ready=1, and addresses beyond the 3rd are untouched.
- Busy: a second i_req_valid during a read burst -> not accepted until the burst's final response handshake; accepted in the following IDLE cycle.

Source files
------------

// File: rtl/data_ram_master.sv
// data_ram_master: initiator-side controller for the 256x16 data RAM.
// Accepts single-word or burst fill/read requests over valid/ready, drives
// the RAM write/read strobes and returns read words through a registered
// memory buffer (MBR) with response backpressure.
// Optional build macro: DATA_RAM_MASTER_BOUND_CHK_EN -- when defined, a request
// whose burst would run past the top address is accepted but dropped, and
// o_err pulses for one cycle. When undefined, addresses wrap and o_err is 0.
module data_ram_master #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_write,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [ADDR_W-1:0] i_req_len,
    input  logic [DATA_W-1:0] i_req_wdata,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_data,
    output logic              o_rsp_last,
    output logic              o_err,
    output logic              ctrl_write,
    output logic [ADDR_W-1:0] o_addr_write,
    output logic [DATA_W-1:0] o_data_write,
    output logic              ctrl_read,
    output logic [ADDR_W-1:0] o_addr_read,
    input  logic [DATA_W-1:0] i_data_read
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_RSP   = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;      // current burst address
    logic [ADDR_W-1:0] r_len;       // words remaining after the current one
    logic [DATA_W-1:0] r_wdata;     // fill value
    logic [DATA_W-1:0] r_mbr;       // memory buffer register
    logic              r_req_ready;
    logic              r_rsp_valid;
    logic              r_rsp_last;
    logic              r_ctrl_write;
    logic              r_ctrl_read;

    logic              w_accept;
    logic              w_len_zero;

    assign w_accept   = i_req_valid & r_req_ready;
    assign w_len_zero = (r_len == '0);

`ifdef DATA_RAM_MASTER_BOUND_CHK_EN
    logic              r_err;
    logic [ADDR_W:0]   w_end;
    logic              w_oob;

    // One extra bit catches bursts that would run past the top address.
    assign w_end = {1'b0, i_req_addr} + {1'b0, i_req_len};
    assign w_oob = w_end[ADDR_W];
    assign o_err = r_err;
`else
    assign o_err = 1'b0;
`endif

    // Address and data registers feed the RAM ports directly; the strobes
    // alone qualify them, so no request input reaches the RAM combinationally.
    assign o_req_ready  = r_req_ready;
    assign o_rsp_valid  = r_rsp_valid;
    assign o_rsp_data   = r_mbr;
    assign o_rsp_last   = r_rsp_last;
    assign ctrl_write   = r_ctrl_write;
    assign o_addr_write = r_addr;
    assign o_data_write = r_wdata;
    assign ctrl_read    = r_ctrl_read;
    assign o_addr_read  = r_addr;

    // Control FSM: every output flag is loaded alongside the state it belongs to.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_len        <= '0;
            r_wdata      <= '0;
            r_mbr        <= '0;
            r_req_ready  <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_last   <= 1'b0;
            r_ctrl_write <= 1'b0;
            r_ctrl_read  <= 1'b0;
`ifdef DATA_RAM_MASTER_BOUND_CHK_EN
            r_err        <= 1'b0;
`endif
        end else begin
`ifdef DATA_RAM_MASTER_BOUND_CHK_EN
            r_err <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr      <= i_req_addr;
                        r_len       <= i_req_len;
                        r_wdata     <= i_req_wdata;
                        r_req_ready <= 1'b0;
`ifdef DATA_RAM_MASTER_BOUND_CHK_EN
                        if (w_oob) begin
                            r_state <= S_ERR;
                            r_err   <= 1'b1;
                        end else
`endif
                        if (i_req_write) begin
                            r_state      <= S_WRITE;
                            r_ctrl_write <= 1'b1;
                        end else begin
                            r_state     <= S_READ;
                            r_ctrl_read <= 1'b1;
                        end
                    end
                end

                S_WRITE: begin
                    // One strobe per cycle; the burst ends on the strobe with
                    // nothing left to write.
                    r_addr <= r_addr + 1'b1;
                    r_len  <= r_len - 1'b1;
                    if (w_len_zero) begin
                        r_state      <= S_IDLE;
                        r_ctrl_write <= 1'b0;
                        r_req_ready  <= 1'b1;
                    end
                end

                S_READ: begin
                    r_mbr       <= i_data_read;
                    r_ctrl_read <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_rsp_last  <= w_len_zero;
                    r_state     <= S_RSP;
                end

                S_RSP: begin
                    // MBR is untouched here, so the word holds while stalled.
                    if (i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_last  <= 1'b0;
                        if (w_len_zero) begin
                            r_state     <= S_IDLE;
                            r_req_ready <= 1'b1;
                        end else begin
                            r_addr      <= r_addr + 1'b1;
                            r_len       <= r_len - 1'b1;
                            r_ctrl_read <= 1'b1;
                            r_state     <= S_READ;
                        end
                    end
                end

`ifdef DATA_RAM_MASTER_BOUND_CHK_EN
                S_ERR: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                end
`endif

                default: begin
                    r_state      <= S_IDLE;
                    r_req_ready  <= 1'b1;
                    r_rsp_valid  <= 1'b0;
                    r_rsp_last   <= 1'b0;
                    r_ctrl_write <= 1'b0;
                    r_ctrl_read  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_ram_master.sv
// Scoreboard bench for data_ram_master: stimulus pushes expected RAM accesses
// and read responses into queues, monitors pop and compare them.
module tb_data_ram_master;
    localparam int AW = 8;
    localparam int DW = 16;

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic          i_req_valid;
    logic          o_req_ready;
    logic          i_req_write;
    logic [AW-1:0] i_req_addr;
    logic [AW-1:0] i_req_len;
    logic [DW-1:0] i_req_wdata;
    logic          o_rsp_valid;
    logic          i_rsp_ready;
    logic [DW-1:0] o_rsp_data;
    logic          o_rsp_last;
    logic          o_err;
    logic          ctrl_write;
    logic [AW-1:0] o_addr_write;
    logic [DW-1:0] o_data_write;
    logic          ctrl_read;
    logic [AW-1:0] o_addr_read;
    logic [DW-1:0] i_data_read;

    always #5 i_clk = ~i_clk;

    data_ram_master #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_write(i_req_write), .i_req_addr(i_req_addr),
        .i_req_len(i_req_len), .i_req_wdata(i_req_wdata),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_rsp_data(o_rsp_data), .o_rsp_last(o_rsp_last), .o_err(o_err),
        .ctrl_write(ctrl_write), .o_addr_write(o_addr_write),
        .o_data_write(o_data_write), .ctrl_read(ctrl_read),
        .o_addr_read(o_addr_read), .i_data_read(i_data_read)
    );

    function automatic logic [DW-1:0] pat(input int i);
        return 16'hA500 ^ 16'(i);
    endfunction

    // RAM model: synchronous write, combinational read
    logic [DW-1:0] ram [0:255];
    logic          ram_load;
    always @(posedge i_clk) begin
        if (ram_load) begin
            for (int i = 0; i < 256; i++) ram[i] <= pat(i);
        end else if (ctrl_write) begin
            ram[o_addr_write] <= o_data_write;
        end
    end
    assign i_data_read = ram[o_addr_read];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: unexpected event at %0t", nm, $time);
    endtask

    // Scoreboard queues
    logic [AW-1:0]    raq [$];   // expected read addresses
    logic [AW+DW-1:0] wq  [$];   // expected {addr, data} write strobes
    logic [DW:0]      rq  [$];   // expected {last, data} responses
    logic [DW-1:0]    exp_mem [0:255];

    // Response ready pattern: mode 0 = always ready, mode 1 = 1,0,0 repeating
    int rdy_mode = 0;
    int tgl      = 0;
    always @(posedge i_clk) begin
        #1;
        tgl = tgl + 1;
        i_rsp_ready = (rdy_mode == 0) ? 1'b1 : ((tgl % 3) == 0);
    end

    // Monitor: checks every RAM strobe and response against the queues
    logic          stall_q = 1'b0;
    logic [DW:0]   hold_q  = '0;
    int            err_cnt = 0;
    always @(negedge i_clk) begin
        logic [AW+DW-1:0] ew;
        logic [DW:0]      er;
        logic [AW-1:0]    ea;
        if (o_err) err_cnt <= err_cnt + 1;
        if (ctrl_write) begin
            chk("wr_rd_exclusive", {31'b0, ctrl_read}, 32'd0);
            if (wq.size() == 0) fail("wr_unexpected");
            else begin
                ew = wq.pop_front();
                chk("wr_addr", {24'b0, o_addr_write}, {24'b0, ew[AW+DW-1:DW]});
                chk("wr_data", {16'b0, o_data_write}, {16'b0, ew[DW-1:0]});
            end
        end
        if (ctrl_read) begin
            if (raq.size() == 0) fail("rd_unexpected");
            else begin
                ea = raq.pop_front();
                chk("rd_addr", {24'b0, o_addr_read}, {24'b0, ea});
            end
        end
        if (o_rsp_valid) begin
            if (stall_q) chk("rsp_hold", {15'b0, o_rsp_last, o_rsp_data}, {15'b0, hold_q});
            if (i_rsp_ready) begin
                stall_q <= 1'b0;
                if (rq.size() == 0) fail("rsp_unexpected");
                else begin
                    er = rq.pop_front();
                    chk("rsp_data", {16'b0, o_rsp_data}, {16'b0, er[DW-1:0]});
                    chk("rsp_last", {31'b0, o_rsp_last}, {31'b0, er[DW]});
                end
            end else begin
                stall_q <= 1'b1;
                hold_q  <= {o_rsp_last, o_rsp_data};
            end
        end else begin
            stall_q <= 1'b0;
        end
    end

    // Present a request, wait for acceptance; returns just after the accepting edge.
    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [AW-1:0] l,
                         input logic [DW-1:0] d, input bit push, output int waited);
        logic [AW-1:0] ad;
        bit            drop;
        drop = 1'b0;
`ifdef DATA_RAM_MASTER_BOUND_CHK_EN
        drop = (int'(a) + int'(l)) > 255;
`endif
        if (push && !drop) begin
            for (int k = 0; k <= int'(l); k++) begin
                ad = a + AW'(k);
                if (w) begin
                    wq.push_back({ad, d});
                    exp_mem[ad] = d;
                end else begin
                    raq.push_back(ad);
                    rq.push_back({(k == int'(l)), exp_mem[ad]});
                end
            end
        end
        i_req_valid = 1'b1;
        i_req_write = w;
        i_req_addr  = a;
        i_req_len   = l;
        i_req_wdata = d;
        for (waited = 1; waited <= 3000; waited++) begin
            @(negedge i_clk);
            if (o_req_ready) break;
        end
        if (waited > 3000) fail("req_accept_timeout");
        @(posedge i_clk);
        #1;
        i_req_valid = 1'b0;
    endtask

    // Count cycles after acceptance until ready returns, noting first events.
    task automatic wait_done(input string nm, input int exp_cyc,
                             output int frd, output int fvld, output int ferr);
        int cyc;
        frd = -1; fvld = -1; ferr = -1;
        for (cyc = 1; cyc <= 3000; cyc++) begin
            @(negedge i_clk);
            if (ctrl_read   && frd  < 0) frd  = cyc;
            if (o_rsp_valid && fvld < 0) fvld = cyc;
            if (o_err       && ferr < 0) ferr = cyc;
            if (o_req_ready) break;
        end
        if (cyc > 3000) fail({nm, "_timeout"});
        else if (exp_cyc > 0) chk(nm, cyc, exp_cyc);
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        int w8, frd, fvld, ferr;
        for (int i = 0; i < 256; i++) exp_mem[i] = pat(i);
        i_rst_n     = 1'b0;
        ram_load    = 1'b1;
        i_req_valid = 1'b0;
        i_req_write = 1'b0;
        i_req_addr  = '0;
        i_req_len   = '0;
        i_req_wdata = '0;
        repeat (2) @(posedge i_clk);

        // Reset state
        @(negedge i_clk);
        chk("rst_req_ready",  {31'b0, o_req_ready}, 32'd1);
        chk("rst_rsp_valid",  {31'b0, o_rsp_valid}, 32'd0);
        chk("rst_rsp_last",   {31'b0, o_rsp_last},  32'd0);
        chk("rst_err",        {31'b0, o_err},       32'd0);
        chk("rst_ctrl",       {30'b0, ctrl_write, ctrl_read}, 32'd0);
        chk("rst_addrs",      {16'b0, o_addr_write, o_addr_read}, 32'd0);
        chk("rst_data",       {o_data_write, o_rsp_data}, 32'd0);
        i_rst_n  = 1'b1;
        ram_load = 1'b0;
        @(posedge i_clk);
        #1;

        // Single fill then single read-back
        issue(1'b1, 8'h10, 8'd0, 16'hBEEF, 1'b1, w8);
        wait_done("fill1_cycles", 2, frd, fvld, ferr);
        issue(1'b0, 8'h10, 8'd0, 16'h0000, 1'b1, w8);
        wait_done("read1_cycles", 3, frd, fvld, ferr);
        chk("read1_ctrl_read_cycle", frd, 1);
        chk("read1_valid_cycle", fvld, 2);

        // Burst fill, burst read with stalling consumer
        issue(1'b1, 8'h20, 8'd3, 16'h1234, 1'b1, w8);
        wait_done("fill4_cycles", 5, frd, fvld, ferr);
        rdy_mode = 1;
        issue(1'b0, 8'h20, 8'd3, 16'h0000, 1'b1, w8);
        wait_done("read4_stall", -1, frd, fvld, ferr);
        rdy_mode = 0;
        @(posedge i_clk);
        #1;

        // Wrap across the top address
        issue(1'b0, 8'hFE, 8'd2, 16'h0000, 1'b1, w8);
`ifdef DATA_RAM_MASTER_BOUND_CHK_EN
        wait_done("wrap_err_cycles", 2, frd, fvld, ferr);
        chk("wrap_err_cycle", ferr, 1);
        chk("wrap_no_read", frd, -1);
        chk("wrap_no_rsp", fvld, -1);
`else
        wait_done("wrap_cycles", 7, frd, fvld, ferr);
`endif

        // Busy: second request held during a burst, accepted in the next IDLE cycle
        issue(1'b0, 8'h20, 8'd3, 16'h0000, 1'b1, w8);
        issue(1'b0, 8'h10, 8'd0, 16'h0000, 1'b1, w8);
        chk("busy_accept_wait", w8, 9);
        wait_done("busy_second_cycles", 3, frd, fvld, ferr);

        // Reset during the 3rd strobe of an 8-word fill
        wq.push_back({8'h40, 16'h5555});
        wq.push_back({8'h41, 16'h5555});
        wq.push_back({8'h42, 16'h5555});
        exp_mem[8'h40] = 16'h5555;
        exp_mem[8'h41] = 16'h5555;
        issue(1'b1, 8'h40, 8'd7, 16'h5555, 1'b0, w8);
        repeat (3) @(negedge i_clk);
        #1;
        i_rst_n = 1'b0;
        #1;
        chk("rst_mid_ctrl_write", {31'b0, ctrl_write}, 32'd0);
        chk("rst_mid_req_ready",  {31'b0, o_req_ready}, 32'd1);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        repeat (2) @(negedge i_clk);
        chk("post_rst_idle", {29'b0, o_req_ready, ctrl_write, ctrl_read}, 32'd4);
        chk("post_rst_ram40", {16'b0, ram[8'h40]}, 32'h5555);
        for (int i = 8'h43; i <= 8'h47; i++) chk("post_rst_untouched", {16'b0, ram[i]}, {16'b0, pat(i)});
        @(posedge i_clk);
        #1;
        issue(1'b0, 8'h40, 8'd7, 16'h0000, 1'b1, w8);
        wait_done("post_rst_read_cycles", 17, frd, fvld, ferr);

        // Full RAM fill and read-back
        issue(1'b1, 8'h00, 8'd255, 16'h0F0F, 1'b1, w8);
        wait_done("full_fill_cycles", 257, frd, fvld, ferr);
        issue(1'b0, 8'h00, 8'd255, 16'h0000, 1'b1, w8);
        wait_done("full_read_cycles", 513, frd, fvld, ferr);

        repeat (3) @(posedge i_clk);
        chk("wq_empty",  wq.size(),  0);
        chk("raq_empty", raq.size(), 0);
        chk("rq_empty",  rq.size(),  0);
`ifdef DATA_RAM_MASTER_BOUND_CHK_EN
        chk("err_pulses", err_cnt, 1);
`else
        chk("err_pulses", err_cnt, 0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
